// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg -- shared configuration for the common data bus arbiter.
//   ROB_SIZE_BIT     : ROB index width (macro, overridable on the command line)
//   CDB_NUM_SRC      : number of result sources feeding the CDB
//   cdb_src_e        : source ids (ALU=0, LSB=1, BRU=2)
//   cdb_entry_t      : {rob_idx, value} as held in each source buffer
//   cdb_src_step()   : source id advanced by k, modulo CDB_NUM_SRC
// Optional feature macro used by cdb_arbiter: CDB_LSB_PRIO_EN.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_SRC = 3;
  localparam int unsigned ROB_IDX_W   = `ROB_SIZE_BIT;

  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_BRU = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          value;
  } cdb_entry_t;

  function automatic cdb_src_e cdb_src_step(input cdb_src_e s, input int unsigned k);
    int unsigned t;
    t = (32'(s) + k) % CDB_NUM_SRC;
    return cdb_src_e'(t[1:0]);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo -- per-source result buffer in front of the CDB arbiter.
// Ports:
//   clk_in, rst_in : clock, synchronous active-low reset
//   i_push         : write i_data (ignored while full)
//   i_pop          : drop head entry (ignored while empty)
//   i_flush        : empty the buffer (wins over push/pop)
//   i_data         : entry to write
//   o_full/o_empty : occupancy flags
//   o_head         : oldest entry (valid when !o_empty)
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned SRC_FIFO_DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  cdb_entry_t i_data,
  output logic       o_full,
  output logic       o_empty,
  output cdb_entry_t o_head
);

  localparam int unsigned PTR_W = $clog2(SRC_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t       r_mem [SRC_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(SRC_FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  // A full buffer refuses writes even if the head leaves this cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_in) begin
    if (w_push && rst_in && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- buffers results from ALU, LSB and BRU and broadcasts at most
// one per cycle on the registered common data bus, round-robin between sources.
// Ports:
//   clk_in, rst_in : clock, synchronous active-low reset
//   rdy_in         : global ready; low freezes everything (clear ignored)
//   clear          : mispredict flush; empties buffers, kills the broadcast
//   src_valid/src_ready/src_rob_idx/src_value : per-source push handshake
//   cdb_valid/cdb_rob_idx/cdb_value/cdb_src   : registered broadcast
// Build option: CDB_LSB_PRIO_EN -- a non-empty LSB buffer always wins and
// such grants do not move the round-robin pointer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned SRC_FIFO_DEPTH = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear,
  input  logic [2:0]                  src_valid,
  output logic [2:0]                  src_ready,
  input  logic [3*`ROB_SIZE_BIT-1:0]  src_rob_idx,
  input  logic [95:0]                 src_value,
  output logic                        cdb_valid,
  output logic [`ROB_SIZE_BIT-1:0]    cdb_rob_idx,
  output logic [31:0]                 cdb_value,
  output logic [1:0]                  cdb_src
);

  logic [2:0]            w_full;
  logic [2:0]            w_empty;
  logic [2:0]            w_push;
  logic [2:0]            w_pop;
  logic                  w_flush;
  cdb_entry_t            w_in   [CDB_NUM_SRC];
  cdb_entry_t            w_head [CDB_NUM_SRC];

  logic                  w_grant;
  cdb_src_e              w_winner;
  cdb_src_e              w_cand;
  cdb_src_e              w_rr_next;

  cdb_src_e              r_rr_ptr;
  logic                  r_cdb_valid;
  logic [ROB_IDX_W-1:0]  r_cdb_rob_idx;
  logic [31:0]           r_cdb_value;
  cdb_src_e              r_cdb_src;

  assign src_ready = (rst_in && rdy_in && !clear) ? ~w_full : '0;
  assign w_push    = src_valid & src_ready;
  assign w_flush   = rdy_in && clear;
  assign w_pop     = w_grant ? (3'b001 << w_winner) : '0;

  for (genvar gi = 0; gi < CDB_NUM_SRC; gi++) begin : g_src
    assign w_in[gi] = {src_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W], src_value[gi*32 +: 32]};

    cdb_src_fifo #(
      .SRC_FIFO_DEPTH(SRC_FIFO_DEPTH)
    ) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_flush (w_flush),
      .i_data  (w_in[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi])
    );
  end

  always_comb begin
    w_grant   = 1'b0;
    w_winner  = CDB_SRC_ALU;
    w_cand    = CDB_SRC_ALU;
    w_rr_next = r_rr_ptr;
    if (rdy_in && !clear) begin
`ifdef CDB_LSB_PRIO_EN
      if (!w_empty[CDB_SRC_LSB]) begin
        w_grant  = 1'b1;
        w_winner = CDB_SRC_LSB;
      end
`endif
      for (int unsigned k = 0; k < CDB_NUM_SRC; k++) begin
        w_cand = cdb_src_step(r_rr_ptr, k);
        if (!w_grant && !w_empty[w_cand]) begin
          w_grant   = 1'b1;
          w_winner  = w_cand;
          w_rr_next = cdb_src_step(w_cand, 1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rr_ptr      <= CDB_SRC_ALU;
      r_cdb_valid   <= 1'b0;
      r_cdb_rob_idx <= '0;
      r_cdb_value   <= '0;
      r_cdb_src     <= CDB_SRC_ALU;
    end else if (rdy_in) begin
      if (clear) begin
        r_rr_ptr    <= CDB_SRC_ALU;
        r_cdb_valid <= 1'b0;
      end else begin
        r_cdb_valid <= w_grant;
        r_rr_ptr    <= w_rr_next;
        if (w_grant) begin
          r_cdb_rob_idx <= w_head[w_winner].rob_idx;
          r_cdb_value   <= w_head[w_winner].value;
          r_cdb_src     <= w_winner;
        end
      end
    end
  end

  assign cdb_valid   = r_cdb_valid;
  assign cdb_rob_idx = r_cdb_rob_idx;
  assign cdb_value   = r_cdb_value;
  assign cdb_src     = r_cdb_src;

endmodule
